// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// leading-zero digit enables and saturating overflow for 7-segment drivers.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Start,
  input  logic [WIDTH-1:0]      i_Binary_Num,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [4*DIGITS-1:0]   o_BCD,
  output logic [DIGITS-1:0]     o_Digit_En,
  output logic                  o_Overflow,
  output logic [1:0]            state_dbg
);

  // Handshake: i_Start is sampled only while o_Busy=0 (IDLE or DONE); the
  // accepted edge captures i_Binary_Num, o_Busy stays high for WIDTH cycles,
  // then o_Done pulses for one cycle with the new results already on the outputs.

  localparam int TOT = 4*DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state;
  logic [TOT-1:0]        sr;
  logic [CW-1:0]         cnt;
  logic                  ovf_acc;

  logic [TOT-1:0]        adj;
  logic [TOT-1:0]        shifted;
  logic                  ovf_next;
  logic [4*DIGITS-1:0]   bcd_final;
  logic [DIGITS-1:0]     en_final;
  logic                  any_nz;

  assign state_dbg = state;

  always_comb begin
    adj = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr[WIDTH+4*k +: 4] >= 4'd5)
        adj[WIDTH+4*k +: 4] = sr[WIDTH+4*k +: 4] + 4'd3;
    end
    shifted  = {adj[TOT-2:0], 1'b0};
    // A bit leaving the top digit means the value no longer fits in DIGITS digits.
    ovf_next = ovf_acc | adj[TOT-1];
    bcd_final = ovf_next ? {DIGITS{4'd9}} : shifted[TOT-1:WIDTH];
    en_final = '0;
    any_nz   = 1'b0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      any_nz      = any_nz | (bcd_final[4*k +: 4] != 4'd0);
      en_final[k] = any_nz;
    end
    en_final[0] = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_BCD      <= '0;
      o_Digit_En <= DIGITS'(1);
      o_Overflow <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            sr      <= {{(4*DIGITS){1'b0}}, i_Binary_Num};
            ovf_acc <= 1'b0;
            cnt     <= CW'(WIDTH-1);
            o_Busy  <= 1'b1;
            state   <= CONVERT;
          end else begin
            state   <= IDLE;
          end
        end
        CONVERT: begin
          sr      <= shifted;
          ovf_acc <= ovf_next;
          cnt     <= cnt - CW'(1);
          if (cnt == '0) begin
            o_BCD      <= bcd_final;
            o_Digit_En <= en_final;
            o_Overflow <= ovf_next;
            o_Done     <= 1'b1;
            o_Busy     <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results, for DIGITS=3 and DIGITS=2.
module tb_bin_to_bcd_seq;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  logic          start3 = 1'b0, start2 = 1'b0;
  logic [W-1:0]  bin3 = '0, bin2 = '0;
  logic          busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0]   bcd3;
  logic [7:0]    bcd2;
  logic [2:0]    en3;
  logic [1:0]    en2;
  logic [1:0]    state_dbg3, state_dbg2;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3)) u_dut3 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start3), .i_Binary_Num(bin3),
    .o_Busy(busy3), .o_Done(done3), .o_BCD(bcd3), .o_Digit_En(en3),
    .o_Overflow(ovf3), .state_dbg(state_dbg3)
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(2)) u_dut2 (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start2), .i_Binary_Num(bin2),
    .o_Busy(busy2), .o_Done(done2), .o_BCD(bcd2), .o_Digit_En(en2),
    .o_Overflow(ovf2), .state_dbg(state_dbg2)
  );

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  int cyc_n = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the captured value.
  function automatic void ref_convert(input int v, input int d, output logic [11:0] bcd,
                                      output logic [2:0] en, output logic ovf);
    int p;
    int pk;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    ovf = (v >= p);
    bcd = '0;
    en  = '0;
    pk  = 1;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = ovf ? 4'd9 : 4'((v / pk) % 10);
      en[k] = ovf || (k == 0) || (v >= pk);
      pk = pk * 10;
    end
  endfunction

  // model state, one slot per DUT (0: DIGITS=3, 1: DIGITS=2)
  int          m_cnt[2];
  logic [W-1:0] m_val[2];
  logic        m_busy[2], m_done[2], m_ovf[2];
  logic [11:0] m_bcd[2];
  logic [2:0]  m_en[2];
  int          digs[2];

  always @(posedge clk) cyc_n++;

  always @(posedge clk) begin : model
    logic s;
    logic [W-1:0] b;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? start3 : start2;
      b = (i == 0) ? bin3 : bin2;
      if (!rst_l) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0;
        m_bcd[i] = '0; m_en[i] = 3'b001; m_ovf[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            ref_convert(int'(m_val[i]), digs[i], m_bcd[i], m_en[i], m_ovf[i]);
          end
        end else if (s) begin
          m_val[i]  = b;
          m_busy[i] = 1'b1;
          m_cnt[i]  = W;
        end
      end
    end
  end

  // scoreboard / compare, away from the active edge
  always @(negedge clk) begin
    logic [11:0] e;
    if (chk_en) begin
      check("busy3", busy3, m_busy[0]);
      check("done3", done3, m_done[0]);
      check("bcd3",  bcd3,  m_bcd[0]);
      check("en3",   en3,   m_en[0]);
      check("ovf3",  ovf3,  m_ovf[0]);
      check("busy2", busy2, m_busy[1]);
      check("done2", done2, m_done[1]);
      check("bcd2",  bcd2,  m_bcd[1][7:0]);
      check("en2",   en2,   m_en[1][1:0]);
      check("ovf2",  ovf2,  m_ovf[1]);
      if (done3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lit_bcd3", bcd3, e);
      end
    end
  end

  // driver tasks
  task automatic wait_done3(output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (!done3 && n < 100) begin
      if (busy3) busy_cycles++;
      @(negedge clk);
      n++;
    end
    if (!done3) begin
      checks++; errors++;
      $display("FAIL timeout3: got no done expected done within 100 cycles");
    end
  endtask

  task automatic run3(input logic [W-1:0] v, input logic [11:0] e_bcd,
                      input logic [2:0] e_en, input logic e_ovf, input int e_busy);
    int bc;
    @(negedge clk);
    bin3 = v; start3 = 1'b1;
    exp_q.push_back(e_bcd);
    @(negedge clk);
    start3 = 1'b0;
    wait_done3(bc);
    check("lit_en3", en3, e_en);
    check("lit_ovf3", ovf3, e_ovf);
    if (e_busy > 0) check("lit_busy_cycles", bc, e_busy);
  endtask

  task automatic run2(input logic [W-1:0] v, input logic [7:0] e_bcd,
                      input logic [1:0] e_en, input logic e_ovf);
    int n;
    @(negedge clk);
    bin2 = v; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin @(negedge clk); n++; end
    if (!done2) begin
      checks++; errors++;
      $display("FAIL timeout2: got no done expected done within 100 cycles");
    end
    check("lit_bcd2", bcd2, e_bcd);
    check("lit_en2", en2, e_en);
    check("lit_ovf2", ovf2, e_ovf);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bc;
    int t_prev;
    int dn;
    digs[0] = 3; digs[1] = 2;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0; m_val[i] = '0;
      m_bcd[i] = '0; m_en[i] = 3'b001; m_ovf[i] = 1'b0;
    end
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy3, 1'b0);
    check("rst_bcd", bcd3, 12'h000);
    check("rst_en", en3, 3'b001);
    check("rst_ovf", ovf3, 1'b0);
    rst_l = 1'b1;

    // directed vectors, DIGITS=3
    run3(8'd255, 12'h255, 3'b111, 1'b0, 8);
    run3(8'd0,   12'h000, 3'b001, 1'b0, 8);
    run3(8'd9,   12'h009, 3'b001, 1'b0, 0);
    run3(8'd99,  12'h099, 3'b011, 1'b0, 0);
    run3(8'd100, 12'h100, 3'b111, 1'b0, 0);

    // start while busy is ignored, input changes during conversion are ignored
    @(negedge clk);
    bin3 = 8'd42; start3 = 1'b1;
    exp_q.push_back(12'h042);
    @(negedge clk);
    bin3 = 8'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bin3 = ~bin3;
    end
    start3 = 1'b0;
    wait_done3(bc);
    check("lit_bcd_42", bcd3, 12'h042);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done3) dn++;
    end
    check("single_done", dn, 0);

    // back-to-back with start held high
    @(negedge clk);
    bin3 = 8'd128; start3 = 1'b1;
    for (int n = 0; n < 3; n++) exp_q.push_back(12'h128);
    t_prev = 0;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      wait_done3(bc);
      if (n > 0) check("done_period", cyc_n - t_prev, 9);
      t_prev = cyc_n;
    end
    start3 = 1'b0;

    // DIGITS=2 overflow saturation and recovery
    run2(8'd200, 8'h99, 2'b11, 1'b1);
    run2(8'd57,  8'h57, 2'b11, 1'b0);
    run2(8'd5,   8'h05, 2'b01, 1'b0);

    // reset in the middle of a conversion
    @(negedge clk);
    bin3 = 8'd255; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    check("abort_busy", busy3, 1'b0);
    check("abort_done", done3, 1'b0);
    check("abort_bcd", bcd3, 12'h000);
    check("abort_en", en3, 3'b001);
    check("abort_ovf", ovf3, 1'b0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done3) dn++;
    end
    check("abort_no_done", dn, 0);
    run3(8'd13, 12'h013, 3'b011, 1'b0, 8);

    // exhaustive sweep against the model
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      bin3 = W'(v); start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      wait_done3(bc);
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
